md_frame_parser: RTL

//  Downstream consumer of the metadata-merged output streams. Takes one AXI-Stream

---
 rtl/md_pkg.sv | 40 ++++
 rtl/axis_reg_slice.sv | 56 +++++
 rtl/md_frame_parser.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the metadata header format used by the metadata inserter and the
// frame parser.
//   - Header field offsets and widths within the first beat of a frame.
//   - Parser state encoding.
//   - keep_from_len(): the byte-enable pattern for the last payload beat of a frame.
package md_pkg;

  localparam int unsigned MD_LEN_LSB = 0;
  localparam int unsigned MD_LEN_W   = 16;
  localparam int unsigned MD_SEQ_LSB = 16;
  localparam int unsigned MD_SEQ_W   = 16;
  localparam int unsigned MD_TAG_LSB = 32;
  localparam int unsigned MD_TAG_W   = 32;

  // Widest beat supported by keep_from_len (DW = 512).
  localparam int unsigned MAX_BPB = 64;

  typedef enum logic [1:0] {
    StHdr  = 2'd0,
    StPay  = 2'd1,
    StDrop = 2'd2,
    StPass = 2'd3
  } md_state_t;

  // Last-beat byte enables for a payload of len bytes on a bpb-byte bus: the low
  // (len mod bpb) bytes, or the whole beat when the length is a multiple of the beat size.
  // Bits at and above bpb are always 0.
  function automatic logic [MAX_BPB-1:0] keep_from_len(input logic [15:0] len,
                                                       input int unsigned bpb);
    logic [MAX_BPB-1:0] keep;
    int unsigned        rem;
    rem  = 32'(len) % bpb;
    keep = '0;
    for (int unsigned i = 0; i < MAX_BPB; i++) begin
      keep[i] = (i < bpb) && ((rem == 0) || (i < rem));
    end
    return keep;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-stage AXI-Stream register slice.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   i_s_tdata/tkeep/tlast       upstream beat
//   i_s_tvalid / o_s_tready     upstream handshake; ready whenever the stage is empty or draining
//   o_m_tdata/tkeep/tlast       registered beat
//   o_m_tvalid / i_m_tready     downstream handshake; valid holds with stable data until ready
module axis_reg_slice #(
  parameter int unsigned DW = 128,
  parameter int unsigned KW = DW / 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] i_s_tdata,
  input  logic [KW-1:0] i_s_tkeep,
  input  logic          i_s_tlast,
  input  logic          i_s_tvalid,
  output logic          o_s_tready,
  output logic [DW-1:0] o_m_tdata,
  output logic [KW-1:0] o_m_tkeep,
  output logic          o_m_tlast,
  output logic          o_m_tvalid,
  input  logic          i_m_tready
);

  logic [DW-1:0] r_tdata;
  logic [KW-1:0] r_tkeep;
  logic          r_tlast;
  logic          r_tvalid;
  logic          w_ready;

  assign w_ready = !r_tvalid || i_m_tready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tlast  <= 1'b0;
      r_tvalid <= 1'b0;
    end else if (w_ready) begin
      r_tvalid <= i_s_tvalid;
      if (i_s_tvalid) begin
        r_tdata <= i_s_tdata;
        r_tkeep <= i_s_tkeep;
        r_tlast <= i_s_tlast;
      end
    end
  end

  assign o_s_tready = w_ready;
  assign o_m_tdata  = r_tdata;
  assign o_m_tkeep  = r_tkeep;
  assign o_m_tlast  = r_tlast;
  assign o_m_tvalid = r_tvalid;

endmodule

// File: rtl/md_frame_parser.sv
// Metadata frame parser. The first beat of each frame carries a header {tag, seq, len}; the
// header is published on the md_* sideband, the payload is forwarded with tkeep regenerated
// from len and tlast checked against len. With md_enable low at frame start the frame passes
// through untouched.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   md_enable                  sampled at frame start: 1 = parse header, 0 = pass-through
//   axis_in_*                  input stream (tkeep used only in pass-through)
//   axis_out_*                 payload stream, one register stage after the input
//   md_len/md_seq/md_tag       last accepted header fields
//   md_valid                   one-cycle pulse per accepted header
//   err_short / err_long       one-cycle pulses for early / missing input tlast
//   frame_cnt / err_cnt        wrapping counters of headers and error pulses
module md_frame_parser
  import md_pkg::*;
#(
  parameter int unsigned DW    = 128,
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              md_enable,
  input  logic [DW-1:0]     axis_in_tdata,
  input  logic [DW/8-1:0]   axis_in_tkeep,
  input  logic              axis_in_tlast,
  input  logic              axis_in_tvalid,
  output logic              axis_in_tready,
  output logic [DW-1:0]     axis_out_tdata,
  output logic [DW/8-1:0]   axis_out_tkeep,
  output logic              axis_out_tlast,
  output logic              axis_out_tvalid,
  input  logic              axis_out_tready,
  output logic [15:0]       md_len,
  output logic [15:0]       md_seq,
  output logic [31:0]       md_tag,
  output logic              md_valid,
  output logic              err_short,
  output logic              err_long,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int unsigned BPB = DW / 8;

  md_state_t        r_state;
  logic [15:0]      r_cnt;
  logic [15:0]      r_exp_m1;
  logic [BPB-1:0]   r_last_keep;
  logic [15:0]      r_md_len;
  logic [15:0]      r_md_seq;
  logic [31:0]      r_md_tag;
  logic             r_md_valid;
  logic             r_err_short;
  logic             r_err_long;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic               w_slice_ready;
  logic               w_in_tready;
  logic               w_fire;
  logic               w_is_last;
  logic [15:0]        w_hdr_len;
  logic [15:0]        w_hdr_seq;
  logic [31:0]        w_hdr_tag;
  logic [16:0]        w_exp;
  logic [15:0]        w_exp_m1;
  logic [MAX_BPB-1:0] w_keep_full;
  logic [BPB-1:0]     w_hdr_keep;
  logic               w_unused_keep;
  logic               w_s_tvalid;
  logic [BPB-1:0]     w_s_tkeep;
  logic               w_s_tlast;

  assign w_hdr_len = axis_in_tdata[MD_LEN_LSB +: MD_LEN_W];
  assign w_hdr_seq = axis_in_tdata[MD_SEQ_LSB +: MD_SEQ_W];
  assign w_hdr_tag = axis_in_tdata[MD_TAG_LSB +: MD_TAG_W];

  // Payload beats expected for this header: ceil(len / BPB).
  assign w_exp    = (17'(w_hdr_len) + 17'(BPB - 1)) / 17'(BPB);
  assign w_exp_m1 = 16'(w_exp - 17'd1);

  assign w_keep_full   = keep_from_len(w_hdr_len, BPB);
  assign w_hdr_keep    = w_keep_full[BPB-1:0];
  // Bits above BPB are always zero; folded here only so they are consumed.
  assign w_unused_keep = ^w_keep_full;

  // DROP swallows beats regardless of the output side.
  assign w_in_tready = (r_state == StDrop) ? 1'b1 : w_slice_ready;
  assign w_fire      = axis_in_tvalid && w_in_tready;
  assign w_is_last   = (r_cnt == r_exp_m1);

  // Beat presented to the output register. Only non-DROP states forward, and in those states
  // w_fire already implies the slice is ready.
  always_comb begin
    w_s_tvalid = 1'b0;
    w_s_tkeep  = '0;
    w_s_tlast  = 1'b0;
    unique case (r_state)
      StHdr: begin
        if (!md_enable) begin
          w_s_tvalid = w_fire;
          w_s_tkeep  = axis_in_tkeep;
          w_s_tlast  = axis_in_tlast;
        end
      end
      StPay: begin
        w_s_tvalid = w_fire;
        w_s_tkeep  = w_is_last ? r_last_keep : '1;
        w_s_tlast  = w_is_last || axis_in_tlast;
      end
      StPass: begin
        w_s_tvalid = w_fire;
        w_s_tkeep  = axis_in_tkeep;
        w_s_tlast  = axis_in_tlast;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StHdr;
      r_cnt       <= '0;
      r_exp_m1    <= '0;
      r_last_keep <= '0;
      r_md_len    <= '0;
      r_md_seq    <= '0;
      r_md_tag    <= '0;
      r_md_valid  <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      r_frame_cnt <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_md_valid  <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      if (w_fire) begin
        unique case (r_state)
          StHdr: begin
            if (!md_enable) begin
              // A single-beat pass-through frame leaves us waiting for the next header.
              if (!axis_in_tlast) r_state <= StPass;
            end else begin
              r_md_len    <= w_hdr_len;
              r_md_seq    <= w_hdr_seq;
              r_md_tag    <= w_hdr_tag;
              r_md_valid  <= 1'b1;
              r_frame_cnt <= r_frame_cnt + 1'b1;
              r_cnt       <= '0;
              r_exp_m1    <= w_exp_m1;
              r_last_keep <= w_hdr_keep;
              if (axis_in_tlast) begin
                if (w_hdr_len != 16'd0) begin
                  r_err_short <= 1'b1;
                  r_err_cnt   <= r_err_cnt + 1'b1;
                end
              end else if (w_hdr_len == 16'd0) begin
                r_err_long <= 1'b1;
                r_err_cnt  <= r_err_cnt + 1'b1;
                r_state    <= StDrop;
              end else begin
                r_state <= StPay;
              end
            end
          end
          StPay: begin
            r_cnt <= r_cnt + 16'd1;
            if (axis_in_tlast) begin
              r_state <= StHdr;
              if (!w_is_last) begin
                r_err_short <= 1'b1;
                r_err_cnt   <= r_err_cnt + 1'b1;
              end
            end else if (w_is_last) begin
              r_err_long <= 1'b1;
              r_err_cnt  <= r_err_cnt + 1'b1;
              r_state    <= StDrop;
            end
          end
          StDrop: begin
            if (axis_in_tlast) r_state <= StHdr;
          end
          StPass: begin
            if (axis_in_tlast) r_state <= StHdr;
          end
          default: r_state <= StHdr;
        endcase
      end
    end
  end

  axis_reg_slice #(
    .DW (DW),
    .KW (BPB)
  ) u_out_slice (
    .clk        (clk),
    .reset      (reset),
    .i_s_tdata  (axis_in_tdata),
    .i_s_tkeep  (w_s_tkeep),
    .i_s_tlast  (w_s_tlast),
    .i_s_tvalid (w_s_tvalid),
    .o_s_tready (w_slice_ready),
    .o_m_tdata  (axis_out_tdata),
    .o_m_tkeep  (axis_out_tkeep),
    .o_m_tlast  (axis_out_tlast),
    .o_m_tvalid (axis_out_tvalid),
    .i_m_tready (axis_out_tready)
  );

  assign axis_in_tready = w_in_tready;
  assign md_len         = r_md_len;
  assign md_seq         = r_md_seq;
  assign md_tag         = r_md_tag;
  assign md_valid       = r_md_valid;
  assign err_short      = r_err_short;
  assign err_long       = r_err_long;
  assign frame_cnt      = r_frame_cnt;
  assign err_cnt        = r_err_cnt;

endmodule
